mc_control_fsm: RTL
===================

# mc_control_fsm

Multi-cycle control state machine for the RV32I datapath in `cpu`. It decodes the 7-bit opcode from the instruction register and walks each instruction through fetch, decode, execute, memory and writeback states. In each state it drives the datapath mux selects, the temp-register write enables, and the PC, register-file and memory strobes. It sits directly upstream of the datapath and consumes `alu_bcond` back from the ALU.

## Interface
Parameters:
- `RESET_STATE`, default 4'd0 (IF): state entered on reset.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `opcode`  in  7  IR[6:0]
- `alu_bcond`  in  1  branch condition from ALU, valid in BR state
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_read`, `mem_write`  out  1 each  memory strobes
- `ir_write`, `mdr_write`, `a_write`, `b_write`, `aluout_write`  out  1 each  temp-register enables
- `alu_src_a`  out  1  0 = PC, 1 = A
- `alu_src_b`  out  2  0 = B, 1 = constant 4, 2 = imm, 3 = unused
- `alu_op`  out  2  0 = ADD, 1 = BRANCH (funct3 compare), 2 = R-funct, 3 = I-funct
- `mem_to_reg`  out  2  0 = ALUOut, 1 = MDR, 2 = live alu_out
- `reg_write`  out  1  register-file write enable
- `pc_write`, `pc_write_cond`  out  1 each  PC enable; the datapath enables the PC on `pc_write | (pc_write_cond & alu_bcond)`
- `pc_source`  out  1  0 = live alu_out, 1 = ALUOut
- `is_halted`  out  1  high in HALT
- `state_dbg`  out  4  current state encoding
- `retired`  out  32  count of completed instructions

## Operation
- Moore outputs decode from the state only. Any signal not listed for a state is 0.
- Opcodes:
  - R = 0110011
  - I = 0010011
  - LD = 0000011
  - ST = 0100011
  - BR = 1100011
  - JAL = 1101111
  - JALR = 1100111
  - ECALL = 1110011
- States and outputs:
  - IF(0): mem_read, i_or_d=0, ir_write. Next: ID.
  - ID(1): a_write, b_write, alu_src_a=0, alu_src_b=2, ADD, aluout_write (branch/JAL target). Next by opcode: R->EX_R, I->EX_I, LD/ST->EX_ADDR, BR->BR, JAL->JAL, JALR->JALR_EX, ECALL->HALT, other->PC_INC.
  - EX_R(2): src_a=1, src_b=0, op=2, aluout_write. Next: WB_ALU.
  - EX_I(3): src_a=1, src_b=2, op=3, aluout_write. Next: WB_ALU.
  - EX_ADDR(4): src_a=1, src_b=2, ADD, aluout_write. Next: LD->MEM_LD, ST->MEM_ST.
  - MEM_LD(5): mem_read, i_or_d=1, mdr_write. Next: WB_LD.
  - MEM_ST(6): mem_write, i_or_d=1, plus the PC+4 set. Next: IF.
  - WB_ALU(7): reg_write, mem_to_reg=0, plus the PC+4 set. Next: IF.
  - WB_LD(8): reg_write, mem_to_reg=1, plus the PC+4 set. Next: IF.
  - BR(9): src_a=1, src_b=0, op=1, pc_write_cond, pc_source=1. Next: IF if alu_bcond, else PC_INC.
  - JAL(10): src_a=0, src_b=1, ADD, reg_write, mem_to_reg=2, pc_write, pc_source=1. Next: IF.
  - JALR_EX(11): src_a=1, src_b=2, ADD, aluout_write. Next: JALR_WB.
  - JALR_WB(12): same outputs as JAL. Next: IF. Clearing the LSB of the jump target is the datapath's job.
  - PC_INC(13): the PC+4 set. Next: IF.
  - HALT(14): is_halted=1. Terminal until reset.
  - 15: illegal; go to IF next cycle with all outputs 0.
- PC+4 set: alu_src_a=0, alu_src_b=1, ADD, pc_write, pc_source=0.
- `retired` increments by 1 on every transition into IF from any state other than reset. It wraps at 2^32-1 -> 0. Entering HALT does not count.

## Timing
- While `reset`=0, independent of `clk`:
  - state = RESET_STATE (IF)
  - `retired` = 0
  - every output = 0, including mem_read and ir_write
- After `reset` rises, the IF outputs appear immediately. The first instruction is latched at the next rising edge.
- Cycles per instruction, counted from IF through the last state:
  - R/I: 4
  - LD: 5
  - ST: 4
  - BR taken: 3
  - BR not taken: 4
  - JAL: 3
  - JALR: 4
  - unknown opcode: 3
  - ECALL: 2, then HALT forever
- `opcode` is sampled only in ID and EX_ADDR; it is stable because IR is written only in IF. `alu_bcond` is sampled only in BR.
- Reset asserted mid-instruction aborts that instruction. Register and memory writes are suppressed for the rest of the reset, and no partial count is added.

## Test plan
- Reset: hold `reset`=0 for 3 cycles, then release -> while low, all outputs 0, `state_dbg`=0, `retired`=0. After release, mem_read=1 and ir_write=1.
- R-type: opcode 0110011 -> `state_dbg` sequence 0,1,2,7,0. reg_write=1 only in state 7. `retired` goes 0->1 on re-entering IF.
- Load then store: opcode 0000011 -> 0,1,4,5,8,0. Then 0100011 -> 0,1,4,6,0, with mem_write=1 and i_or_d=1 in state 6. `retired`=2.
- Branch: opcode 1100011 with alu_bcond=1 -> 0,1,9,0. With alu_bcond=0 -> 0,1,9,13,0, pc_source=0 in state 13.
- JALR then ECALL: 1100111 -> 0,1,11,12,0 with mem_to_reg=2. Then 1110011 -> 0,1,14, and is_halted stays 1 for 10+ cycles with `retired` unchanged.
- Mid-op reset: assert `reset`=0 in state 5 (MEM_LD) -> immediately state 0, all outputs 0, `retired`=0, with no reg_write pulse.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM for the RV32I datapath.
// Walks each instruction through fetch/decode/execute/memory/writeback and
// drives the datapath selects, temp-register enables and PC/RF/memory strobes.
// Ports:
//   clk, reset (async, active-low)
//   opcode      : IR[6:0], sampled in ID and EX_ADDR
//   alu_bcond   : branch outcome from the ALU, sampled in BR
//   control outs: memory/temp-register/ALU/PC/register-file controls (Moore)
//   is_halted   : high in HALT
//   state_dbg   : current state encoding
//   retired     : number of completed instructions
module mc_control_fsm #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        alu_bcond,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mdr_write,
    output logic        a_write,
    output logic        b_write,
    output logic        aluout_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  mem_to_reg,
    output logic        reg_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        pc_source,
    output logic        is_halted,
    output logic [3:0]  state_dbg,
    output logic [31:0] retired
);

    localparam int unsigned RET_W = 32;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_BRANCH = 2'd1;
    localparam logic [1:0] ALU_RFUNCT = 2'd2;
    localparam logic [1:0] ALU_IFUNCT = 2'd3;

    localparam logic [1:0] SRCB_B    = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_LIVE   = 2'd2;

    typedef enum logic [3:0] {
        S_IF      = 4'd0,
        S_ID      = 4'd1,
        S_EX_R    = 4'd2,
        S_EX_I    = 4'd3,
        S_EX_ADDR = 4'd4,
        S_MEM_LD  = 4'd5,
        S_MEM_ST  = 4'd6,
        S_WB_ALU  = 4'd7,
        S_WB_LD   = 4'd8,
        S_BR      = 4'd9,
        S_JAL     = 4'd10,
        S_JALR_EX = 4'd11,
        S_JALR_WB = 4'd12,
        S_PC_INC  = 4'd13,
        S_HALT    = 4'd14,
        S_ILLEGAL = 4'd15
    } state_t;

    state_t state;
    state_t next_state;

    // State register and retired-instruction counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= state_t'(RESET_STATE);
            retired <= '0;
        end else begin
            state <= next_state;
            if (next_state == S_IF) begin
                retired <= retired + RET_W'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        next_state = S_IF;
        case (state)
            S_IF: next_state = S_ID;
            S_ID: begin
                case (opcode)
                    OP_R:          next_state = S_EX_R;
                    OP_I:          next_state = S_EX_I;
                    OP_LD, OP_ST:  next_state = S_EX_ADDR;
                    OP_BR:         next_state = S_BR;
                    OP_JAL:        next_state = S_JAL;
                    OP_JALR:       next_state = S_JALR_EX;
                    OP_ECALL:      next_state = S_HALT;
                    default:       next_state = S_PC_INC;
                endcase
            end
            S_EX_R:    next_state = S_WB_ALU;
            S_EX_I:    next_state = S_WB_ALU;
            S_EX_ADDR: next_state = (opcode == OP_LD) ? S_MEM_LD : S_MEM_ST;
            S_MEM_LD:  next_state = S_WB_LD;
            S_MEM_ST:  next_state = S_IF;
            S_WB_ALU:  next_state = S_IF;
            S_WB_LD:   next_state = S_IF;
            S_BR:      next_state = alu_bcond ? S_IF : S_PC_INC;
            S_JAL:     next_state = S_IF;
            S_JALR_EX: next_state = S_JALR_WB;
            S_JALR_WB: next_state = S_IF;
            S_PC_INC:  next_state = S_IF;
            S_HALT:    next_state = S_HALT;
            default:   next_state = S_IF;
        endcase
    end

    // Moore output decode; forced to zero while reset is held so no strobe
    // leaks out during an aborted instruction
    always_comb begin
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mdr_write     = 1'b0;
        a_write       = 1'b0;
        b_write       = 1'b0;
        aluout_write  = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        mem_to_reg    = M2R_ALUOUT;
        reg_write     = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        is_halted     = 1'b0;
        state_dbg     = 4'd0;

        if (reset) begin
            state_dbg = state;

            // Shared PC+4 update: PC + 4 through the live ALU result
            if (state == S_MEM_ST || state == S_WB_ALU ||
                state == S_WB_LD  || state == S_PC_INC) begin
                alu_src_a = 1'b0;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALU_ADD;
                pc_write  = 1'b1;
                pc_source = 1'b0;
            end

            case (state)
                S_IF: begin
                    mem_read = 1'b1;
                    ir_write = 1'b1;
                end
                S_ID: begin
                    // Precompute PC + imm for branch/JAL targets
                    a_write      = 1'b1;
                    b_write      = 1'b1;
                    alu_src_b    = SRCB_IMM;
                    aluout_write = 1'b1;
                end
                S_EX_R: begin
                    alu_src_a    = 1'b1;
                    alu_src_b    = SRCB_B;
                    alu_op       = ALU_RFUNCT;
                    aluout_write = 1'b1;
                end
                S_EX_I: begin
                    alu_src_a    = 1'b1;
                    alu_src_b    = SRCB_IMM;
                    alu_op       = ALU_IFUNCT;
                    aluout_write = 1'b1;
                end
                S_EX_ADDR, S_JALR_EX: begin
                    alu_src_a    = 1'b1;
                    alu_src_b    = SRCB_IMM;
                    aluout_write = 1'b1;
                end
                S_MEM_LD: begin
                    mem_read  = 1'b1;
                    i_or_d    = 1'b1;
                    mdr_write = 1'b1;
                end
                S_MEM_ST: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_WB_ALU: begin
                    reg_write  = 1'b1;
                    mem_to_reg = M2R_ALUOUT;
                end
                S_WB_LD: begin
                    reg_write  = 1'b1;
                    mem_to_reg = M2R_MDR;
                end
                S_BR: begin
                    alu_src_a     = 1'b1;
                    alu_src_b     = SRCB_B;
                    alu_op        = ALU_BRANCH;
                    pc_write_cond = 1'b1;
                    pc_source     = 1'b1;
                end
                S_JAL, S_JALR_WB: begin
                    // Link PC + 4 while jumping to the target held in ALUOut
                    alu_src_a  = 1'b0;
                    alu_src_b  = SRCB_FOUR;
                    reg_write  = 1'b1;
                    mem_to_reg = M2R_LIVE;
                    pc_write   = 1'b1;
                    pc_source  = 1'b1;
                end
                S_HALT: begin
                    is_halted = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
